proc_test_sequencer: RTL and testbench

- Synthesisable, parametrised test sequencer that runs a programmable list of programs on the single-cycle processor core.
- Per test it:
  - optionally holds the core in reset and loads its start PC;
  - runs the core until currentpc reaches an end address;
  - checks MemtoRegOut against an expected value;
  - enforces a per-test watchdog.
- Sits beside the core in FPGA bring-up builds and produces pass/fail status without a simulator.

---
 rtl/proc_test_pkg.sv | 23 ++
 rtl/proc_test_sequencer_wd_counter.sv | 34 +++
 rtl/proc_test_sequencer.sv | 174 +++++++++++++++++
 tb/tb_proc_test_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_test_pkg.sv
// Shared types and sizing helpers for the processor test sequencer.
package proc_test_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        RUN    = 3'd2,
        REPORT = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    localparam int DEFAULT_WD_LIMIT     = 255;
    localparam int DEFAULT_RESET_CYCLES = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/proc_test_sequencer_wd_counter.sv
// Saturating up-counter with synchronous clear; at_limit flags the terminal count.
module wd_counter #(
    parameter int W     = 16,
    parameter int LIMIT = 255
) (
    input  logic CLK,
    input  logic resetl,
    input  logic clr,
    input  logic en,
    output logic at_limit
);

    logic [W-1:0] count_q, count_d;

    assign at_limit = (count_q == W'(LIMIT));

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !at_limit) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/proc_test_sequencer.sv
// Runs a list of programs on the core, checking writeback at an end PC under a per-slot watchdog.
//
// state  | meaning
// IDLE   | core held in reset, waiting for start
// RST    | core held in reset with the slot start PC for RESET_CYCLES cycles
// RUN    | core running, waiting for currentpc >= end PC or watchdog expiry
// REPORT | one-cycle verdict pulse, then next slot or DONE
// DONE   | status sticky, core left running, waiting for start
module proc_test_sequencer
    import proc_test_pkg::*;
#(
    parameter int NUM_TESTS    = 4,
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
    parameter int WD_LIMIT     = DEFAULT_WD_LIMIT,
    parameter int WD_W         = 16
) (
    input  logic                          CLK,
    input  logic                          resetl,
    input  logic                          start,
    input  logic [NUM_TESTS*ADDR_W-1:0]   test_startpc,
    input  logic [NUM_TESTS*ADDR_W-1:0]   test_endpc,
    input  logic [NUM_TESTS*DATA_W-1:0]   test_expected,
    input  logic [NUM_TESTS-1:0]          test_reset_en,
    input  logic [ADDR_W-1:0]             currentpc,
    input  logic [DATA_W-1:0]             MemtoRegOut,
    output logic                          dut_resetl,
    output logic [ADDR_W-1:0]             dut_startpc,
    output logic                          busy,
    output logic                          done,
    output logic                          all_passed,
    output logic                          timeout,
    output logic [NUM_TESTS-1:0]          pass_mask,
    output logic [cnt_w(NUM_TESTS)-1:0]   pass_count,
    output logic [idx_w(NUM_TESTS)-1:0]   test_idx,
    output logic                          result_valid,
    output logic                          result_pass
);

    localparam int IDX_W = idx_w(NUM_TESTS);
    localparam int CNT_W = cnt_w(NUM_TESTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TESTS - 1);

    seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]     test_idx_q, test_idx_d;
    logic [ADDR_W-1:0]    startpc_q, startpc_d;
    logic                 timeout_q, timeout_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rpass_q, rpass_d;
    logic [NUM_TESTS-1:0] pass_mask_q, pass_mask_d;
    logic [CNT_W-1:0]     pass_count_q, pass_count_d;

    logic [ADDR_W-1:0]    start_arr [NUM_TESTS];
    logic [ADDR_W-1:0]    end_arr   [NUM_TESTS];
    logic [DATA_W-1:0]    exp_arr   [NUM_TESTS];
    logic [NUM_TESTS-1:0] reset_en;
    logic                 pc_hit, rst_last, wd_expire;

    for (genvar g = 0; g < NUM_TESTS; g++) begin : g_slot
        assign start_arr[g] = test_startpc[g*ADDR_W +: ADDR_W];
        assign end_arr[g]   = test_endpc[g*ADDR_W +: ADDR_W];
        assign exp_arr[g]   = test_expected[g*DATA_W +: DATA_W];
    end

    // Slot 0 always starts from a clean core.
    assign reset_en = test_reset_en | NUM_TESTS'(1);
    assign pc_hit   = (currentpc >= end_arr[test_idx_q]);

    // Limits are cycle counts and the counters start at 0, so terminal count is limit-1.
    wd_counter #(.W(WD_W), .LIMIT(RESET_CYCLES - 1)) u_rst_cnt (
        .CLK      (CLK),
        .resetl   (resetl),
        .clr      (state_q != RST),
        .en       (state_q == RST),
        .at_limit (rst_last)
    );

    wd_counter #(.W(WD_W), .LIMIT(WD_LIMIT - 1)) u_wd_cnt (
        .CLK      (CLK),
        .resetl   (resetl),
        .clr      (state_q != RUN),
        .en       (state_q == RUN),
        .at_limit (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        test_idx_d   = test_idx_q;
        startpc_d    = startpc_q;
        timeout_d    = timeout_q;
        rvalid_d     = 1'b0;
        rpass_d      = 1'b0;
        pass_mask_d  = pass_mask_q;
        pass_count_d = pass_count_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RST;
                    test_idx_d   = '0;
                    startpc_d    = start_arr[0];
                    timeout_d    = 1'b0;
                    pass_mask_d  = '0;
                    pass_count_d = '0;
                end
            end
            RST: begin
                if (rst_last) state_d = RUN;
            end
            RUN: begin
                if (pc_hit) begin
                    state_d  = REPORT;
                    rvalid_d = 1'b1;
                    rpass_d  = (MemtoRegOut == exp_arr[test_idx_q]);
                end else if (wd_expire) begin
                    state_d   = DONE;
                    rvalid_d  = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            REPORT: begin
                pass_mask_d[test_idx_q] = rpass_q;
                pass_count_d = pass_count_q + CNT_W'(rpass_q);
                if (test_idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    test_idx_d = test_idx_q + IDX_W'(1);
                    if (reset_en[test_idx_d]) begin
                        state_d   = RST;
                        startpc_d = start_arr[test_idx_d];
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q      <= IDLE;
            test_idx_q   <= '0;
            startpc_q    <= '0;
            timeout_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rpass_q      <= 1'b0;
            pass_mask_q  <= '0;
            pass_count_q <= '0;
        end else begin
            state_q      <= state_d;
            test_idx_q   <= test_idx_d;
            startpc_q    <= startpc_d;
            timeout_q    <= timeout_d;
            rvalid_q     <= rvalid_d;
            rpass_q      <= rpass_d;
            pass_mask_q  <= pass_mask_d;
            pass_count_q <= pass_count_d;
        end
    end

    assign dut_resetl   = (state_q == RUN) || (state_q == REPORT) || (state_q == DONE);
    assign dut_startpc  = startpc_q;
    assign busy         = (state_q == RST) || (state_q == RUN) || (state_q == REPORT);
    assign done         = (state_q == DONE);
    assign all_passed   = done && (pass_count_q == CNT_W'(NUM_TESTS)) && !timeout_q;
    assign timeout      = timeout_q;
    assign pass_mask    = pass_mask_q;
    assign pass_count   = pass_count_q;
    assign test_idx     = test_idx_q;
    assign result_valid = rvalid_q;
    assign result_pass  = rpass_q;

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Scoreboard bench: two-slot runs against a simple PC-stepping core model.
module tb_proc_test_sequencer;

    localparam int NT = 2;
    localparam int AW = 64;
    localparam int DW = 64;

    logic           CLK = 1'b0;
    logic           resetl = 1'b0;
    logic           start = 1'b0;
    logic [NT*AW-1:0] test_startpc = '0;
    logic [NT*AW-1:0] test_endpc = '0;
    logic [NT*DW-1:0] test_expected = '0;
    logic [NT-1:0]  test_reset_en = '0;
    logic [AW-1:0]  currentpc;
    logic [DW-1:0]  MemtoRegOut;
    logic           dut_resetl;
    logic [AW-1:0]  dut_startpc;
    logic           busy, done, all_passed, timeout;
    logic [NT-1:0]  pass_mask;
    logic [1:0]     pass_count;
    logic [0:0]     test_idx;
    logic           result_valid, result_pass;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [0:0] idx;
        logic       pass;
    } exp_t;
    exp_t exp_q[$];

    proc_test_sequencer #(
        .NUM_TESTS(NT), .ADDR_W(AW), .DATA_W(DW),
        .RESET_CYCLES(2), .WD_LIMIT(255), .WD_W(16)
    ) dut (
        .CLK(CLK), .resetl(resetl), .start(start),
        .test_startpc(test_startpc), .test_endpc(test_endpc),
        .test_expected(test_expected), .test_reset_en(test_reset_en),
        .currentpc(currentpc), .MemtoRegOut(MemtoRegOut),
        .dut_resetl(dut_resetl), .dut_startpc(dut_startpc),
        .busy(busy), .done(done), .all_passed(all_passed), .timeout(timeout),
        .pass_mask(pass_mask), .pass_count(pass_count), .test_idx(test_idx),
        .result_valid(result_valid), .result_pass(result_pass)
    );

    always #5 CLK = ~CLK;

    // Core model: reloads start PC while held in reset, otherwise steps by 4.
    logic [AW-1:0] model_pc;
    logic          stuck = 1'b0;
    logic [DW-1:0] val1 = '0;
    always @(posedge CLK) begin
        if (!dut_resetl) model_pc <= dut_startpc;
        else             model_pc <= model_pc + 64'd4;
    end
    assign currentpc   = stuck ? 64'h10 : model_pc;
    assign MemtoRegOut = (currentpc == 64'h30) ? 64'hF :
                         (currentpc == 64'h58) ? val1 : 64'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: idx=%0d pass=%0b, required no result", test_idx, result_pass);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_result_idx", 64'(test_idx), 64'(e.idx));
                check("sb_result_pass", 64'(result_pass), 64'(e.pass));
            end
        end
    end

    int cyc = 0;
    int run_cyc = -1;
    int to_cyc = -1;
    logic prev_rl = 1'b0;
    logic prev_to = 1'b0;
    logic [63:0] rst_pcs[$];
    always @(negedge CLK) begin
        cyc++;
        if (busy && !dut_resetl) rst_pcs.push_back(dut_startpc);
        if (!prev_rl && dut_resetl) run_cyc = cyc;
        if (!prev_to && timeout) to_cyc = cyc;
        prev_rl = dut_resetl;
        prev_to = timeout;
    end

    task automatic setup(input logic [63:0] s1, input logic re1, input logic [63:0] v1, input logic stk);
        test_startpc  = {s1, 64'h0};
        test_endpc    = {64'h58, 64'h30};
        test_expected = {64'h123456789ABCDEF0, 64'hF};
        test_reset_en = {re1, 1'b1};
        val1  = v1;
        stuck = stk;
    endtask

    task automatic push_exp(input logic [0:0] idx, input logic pass);
        exp_t e;
        e.idx  = idx;
        e.pass = pass;
        exp_q.push_back(e);
    endtask

    task automatic pulse_start();
        rst_pcs.delete();
        run_cyc = -1;
        to_cyc  = -1;
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (!done && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_wait_done: done=0 after %0d cycles, required 1", tag, max_cyc);
        end
        @(negedge CLK);
        check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_slot1(input string tag);
        int n = 0;
        while (!(test_idx == 1'b1 && busy && dut_resetl && !result_valid) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_reach_slot1"}, 64'(n < 300), 64'd1);
    endtask

    task automatic check_status(input string tag, input logic [1:0] mask, input logic [1:0] cnt,
                                input logic ap, input logic to);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_pass_mask"}, 64'(pass_mask), 64'(mask));
        check({tag, "_pass_count"}, 64'(pass_count), 64'(cnt));
        check({tag, "_all_passed"}, 64'(all_passed), 64'(ap));
        check({tag, "_timeout"}, 64'(timeout), 64'(to));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dut_resetl"}, 64'(dut_resetl), 64'd0);
        check({tag, "_dut_startpc"}, dut_startpc, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_all_passed"}, 64'(all_passed), 64'd0);
        check({tag, "_timeout"}, 64'(timeout), 64'd0);
        check({tag, "_result_valid"}, 64'(result_valid), 64'd0);
        check({tag, "_result_pass"}, 64'(result_pass), 64'd0);
        check({tag, "_pass_mask"}, 64'(pass_mask), 64'd0);
        check({tag, "_pass_count"}, 64'(pass_count), 64'd0);
        check({tag, "_test_idx"}, 64'(test_idx), 64'd0);
    endtask

    initial begin
        setup(64'h0, 1'b0, 64'h123456789ABCDEF0, 1'b0);
        repeat (3) @(negedge CLK);
        check_reset("por");
        resetl = 1'b1;
        @(negedge CLK);

        // Both slots pass; a start pulse during slot 1 RUN must be ignored.
        push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b1);
        pulse_start();
        wait_slot1("t1");
        @(negedge CLK);
        @(negedge CLK) start = 1'b1;
        @(negedge CLK) start = 1'b0;
        check("t1_ign_test_idx", 64'(test_idx), 64'd1);
        check("t1_ign_pass_count", 64'(pass_count), 64'd1);
        check("t1_ign_busy", 64'(busy), 64'd1);
        wait_done("t1", 300);
        check_status("t1", 2'b11, 2'd2, 1'b1, 1'b0);
        check("t1_rst_cycles", 64'(rst_pcs.size()), 64'd2);

        // Slot 1 writeback wrong.
        setup(64'h0, 1'b0, 64'h0, 1'b0);
        push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b0);
        pulse_start();
        wait_done("t2", 300);
        check_status("t2", 2'b01, 2'd1, 1'b0, 1'b0);

        // Slot 1 requests reset with its own start PC.
        setup(64'h40, 1'b1, 64'h123456789ABCDEF0, 1'b0);
        push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b1);
        pulse_start();
        wait_done("t4", 300);
        check_status("t4", 2'b11, 2'd2, 1'b1, 1'b0);
        check("t4_rst_cycles", 64'(rst_pcs.size()), 64'd4);
        if (rst_pcs.size() == 4) begin
            check("t4_rst_pc0", rst_pcs[0], 64'h0);
            check("t4_rst_pc1", rst_pcs[1], 64'h0);
            check("t4_rst_pc2", rst_pcs[2], 64'h40);
            check("t4_rst_pc3", rst_pcs[3], 64'h40);
        end

        // PC stuck below end address: watchdog expiry.
        setup(64'h0, 1'b0, 64'h123456789ABCDEF0, 1'b1);
        push_exp(1'b0, 1'b0);
        pulse_start();
        wait_done("t3", 400);
        check_status("t3", 2'b00, 2'd0, 1'b0, 1'b1);
        check("t3_test_idx", 64'(test_idx), 64'd0);
        check("t3_wd_cycles", 64'(to_cyc - run_cyc), 64'd255);

        // Asynchronous reset mid-RUN of slot 1, then a clean rerun.
        setup(64'h0, 1'b0, 64'h123456789ABCDEF0, 1'b0);
        push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b1);
        pulse_start();
        wait_slot1("t5");
        @(negedge CLK);
        #2 resetl = 1'b0;
        #1 check_reset("t5_async");
        exp_q.delete();
        @(negedge CLK) resetl = 1'b1;
        @(negedge CLK);
        push_exp(1'b0, 1'b1);
        push_exp(1'b1, 1'b1);
        pulse_start();
        wait_done("t5_rerun", 300);
        check_status("t5_rerun", 2'b11, 2'd2, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
